// File: rtl/flex_cnt_pkg.sv
// rtl/flex_cnt_pkg.sv - shared state type and reset constant for the flex counters
package flex_cnt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fdc_state_t;

    localparam int FDC_RST_COUNT = '0;

endpackage

// File: rtl/flex_down_counter.sv
// rtl/flex_down_counter.sv - loadable one-shot/auto-reload down counter with terminal-count flag
// Optional half_flag output is enabled by defining FLEX_DOWN_COUNTER_HALF_EN.
module flex_down_counter
    import flex_cnt_pkg::*;
#(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    start,
    input  logic                    count_enable,
    input  logic                    reload_mode,
    input  logic [NUM_CNT_BITS-1:0] load_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
`ifdef FLEX_DOWN_COUNTER_HALF_EN
    output logic                    half_flag,
`endif
    output logic                    zero_flag,
    output logic                    busy
);

    localparam logic [NUM_CNT_BITS-1:0] RST_COUNT = NUM_CNT_BITS'(FDC_RST_COUNT);
    localparam logic [NUM_CNT_BITS-1:0] ONE       = NUM_CNT_BITS'(1);

    fdc_state_t              state_q, state_d;
    logic [NUM_CNT_BITS-1:0] count_q, count_d;
    logic [NUM_CNT_BITS-1:0] load_q,  load_d;
    logic                    zero_q,  zero_d;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        load_d  = load_q;
        zero_d  = zero_q;

        if (clear) begin
            state_d = IDLE;
            count_d = RST_COUNT;
            zero_d  = 1'b0;
        end else if (start) begin
            if (load_val != RST_COUNT) begin
                load_d  = load_val;
                count_d = load_val;
                zero_d  = 1'b0;
                state_d = RUN;
            end else begin
                count_d = RST_COUNT;
                zero_d  = 1'b1;
                state_d = DONE;
            end
        end else begin
            case (state_q)
                RUN: begin
                    if (count_enable) begin
                        if (count_q > ONE) begin
                            count_d = count_q - ONE;
                        end else if (count_q == ONE) begin
                            count_d = RST_COUNT;
                            zero_d  = 1'b1;
                        end else if (reload_mode) begin
                            count_d = load_q;
                            zero_d  = 1'b0;
                        end else begin
                            state_d = DONE;
                            count_d = RST_COUNT;
                            zero_d  = 1'b1;
                        end
                    end
                end
                DONE: begin
                    count_d = RST_COUNT;
                    zero_d  = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                    count_d = RST_COUNT;
                    zero_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            count_q <= RST_COUNT;
            load_q  <= RST_COUNT;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            load_q  <= load_d;
            zero_q  <= zero_d;
        end
    end

`ifdef FLEX_DOWN_COUNTER_HALF_EN
    logic half_q, half_d;

    // A fresh start always loads count above load>>1, so this also covers the clear-on-start case.
    always_comb begin
        half_d = (state_d == RUN) && (count_d <= (load_d >> 1));
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            half_q <= 1'b0;
        end else begin
            half_q <= half_d;
        end
    end

    assign half_flag = half_q;
`endif

    assign count_out = count_q;
    assign zero_flag = zero_q;
    assign busy      = (state_q == RUN);

endmodule

// File: doc/flex_down_counter.md
Name: flex_down_counter

Overview:
- Programmable, loadable down counter with a terminal-count flag. It is the counting-down counterpart to the design's flex up-counter.
- Loads a start value, decrements on each enabled cycle, and flags arrival at zero.
- Supports one-shot and auto-reload modes.
- Used as a countdown timer for timeouts, bit/baud periods and pixel/line countdowns in the GPU datapath.

Parameters:
- NUM_CNT_BITS, 4, width of the counter, the load value and the internal load register.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- n_rst  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous clear; highest priority after reset.
- start  input  1  single-cycle pulse: capture load_val and begin counting.
- count_enable  input  1  decrement qualifier.
- reload_mode  input  1  1 = auto-reload at terminal count; 0 = one-shot. Sampled every cycle.
- load_val  input  NUM_CNT_BITS  start value; sampled only on the cycle start is high.
- count_out  output  NUM_CNT_BITS  current count; registered.
- zero_flag  output  1  terminal count reached; registered.
- busy  output  1  high in state RUN; registered/decoded from state register.

Behaviour:
- Reset: n_rst low forces, asynchronously, state=IDLE, count_out=0, zero_flag=0, busy=0, load register=0.
- States: IDLE, RUN, DONE.
- Priority each cycle: clear > start > count_enable.
- clear: next state=IDLE, count_out=0, zero_flag=0. The load register is preserved.
- start with load_val≠0:
  - capture load_val into the load register;
  - count_out=load_val, zero_flag=0, next state=RUN;
  - no decrement occurs that cycle.
- start while in RUN or DONE is a restart with the same effect.
- start with load_val=0: count_out=0, zero_flag=1, next state=DONE, in either mode.
- RUN with count_enable=1:
  - count_out>1: count_out-=1, zero_flag stays 0.
  - count_out==1: count_out=0, zero_flag=1, remain in RUN.
  - count_out==0 (zero_flag=1), reload_mode=1: count_out=load register, zero_flag=0, remain in RUN.
  - count_out==0 (zero_flag=1), reload_mode=0: next state=DONE, count_out=0, zero_flag=1.
- RUN with count_enable=0: hold all state.
- DONE: hold count_out=0 and zero_flag=1; ignore count_enable. Leave only via start, clear or reset.
- IDLE: ignore count_enable; outputs hold at 0.
- Period in reload mode is load_val+1 enabled cycles, with zero_flag high for exactly one enabled interval per period.
- Arithmetic: unsigned, modulo 2^NUM_CNT_BITS. Decrementing from 0 never occurs by construction.
- Full-scale load (all ones) is legal.
- Reset asserted mid-count aborts immediately. After reset release the block waits in IDLE for a start.

Optional Feature:
- Macro: FLEX_DOWN_COUNTER_HALF_EN.
- Defined:
  - adds output half_flag (1 bit, reset 0);
  - half_flag is registered high in RUN while count_out <= (load register >> 1);
  - it is cleared by start, clear, reset, and on entry to DONE.
- Undefined: the port and its logic are absent, and all other behaviour is identical.

Decomposition:
- Shared package flex_cnt_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} fdc_state_t;
  - localparam FDC_RST_COUNT = '0.
- Single module; no sub-module is natural. Next-state logic lives in one combinational block and registers in one flop block.

Test Plan (all with NUM_CNT_BITS=4):
- Reset mid-count: start with load_val=9, run 3 enabled cycles, pulse n_rst low between clock edges. Expect count_out=0, zero_flag=0, busy=0 immediately, and IDLE after release.
- One-shot: start with load_val=3, reload_mode=0, enable held high. Expect count_out 3,2,1,0, then zero_flag=1 and DONE; further enables keep count_out=0.
- Auto-reload: start with load_val=2, reload_mode=1, enable held. Expect sequence 2,1,0,2,1,0. zero_flag high only at each 0 (period 3), and busy stays 1.
- Priority and stall:
  - start with load_val=5 together with count_enable gives count_out=5 (no decrement);
  - enable low for 4 cycles holds the count;
  - clear together with start gives count_out=0 and IDLE.
- Boundaries:
  - start with load_val=0 gives zero_flag=1 and DONE the next cycle;
  - start with load_val=15 counts down through 0 without wrapping;
  - start issued mid-run restarts from the new load_val.
- Optional feature (with FLEX_DOWN_COUNTER_HALF_EN): load_val=8. Expect half_flag rising when count_out=4 and falling when DONE is entered.
